// File: rtl/dcpu16_mslave.sv
// Wishbone F-BUS / G-BUS responder that serves both CPU buses from one shared single-port RAM.
// The two buses take turns (round-robin) and each access may be stretched by WS wait states.
module dcpu16_mslave #(
  parameter int AW = 16,
  parameter int WS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  output logic [15:0] g_dto,
  output logic        g_ack,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dti,
  output logic [15:0] f_dto,
  output logic        f_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  localparam logic [3:0] WS_L = 4'(WS);

  state_e          state_q, state_d;
  logic            last_g_q, last_g_d;
  logic            gnt_g_q, gnt_g_d;
  logic            wre_q, wre_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [15:0]     dti_q, dti_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            g_ack_q, g_ack_d;
  logic            f_ack_q, f_ack_d;
  logic [15:0]     g_dto_q, g_dto_d;
  logic [15:0]     f_dto_q, f_dto_d;

  logic [15:0]     mem [2**AW];
  logic            access;
  logic            pick_g;
  logic [15:0]     rd_data;

  assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign rd_data = mem[adr_q];
  // On a tie, serve the bus that was not granted last.
  assign pick_g  = g_stb && (!f_stb || !last_g_q);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    state_d  = state_q;
    last_g_d = last_g_q;
    gnt_g_d  = gnt_g_q;
    wre_d    = wre_q;
    adr_d    = adr_q;
    dti_d    = dti_q;
    cnt_d    = cnt_q;
    g_ack_d  = 1'b0;
    f_ack_d  = 1'b0;
    g_dto_d  = g_dto_q;
    f_dto_d  = f_dto_q;

    unique case (state_q)
      IDLE: begin
        if (g_stb || f_stb) begin
          state_d  = BUSY;
          gnt_g_d  = pick_g;
          last_g_d = pick_g;
          adr_d    = pick_g ? g_adr[AW-1:0] : f_adr[AW-1:0];
          wre_d    = !pick_g && f_wre;
          dti_d    = f_dti;
          cnt_d    = WS_L;
        end
      end
      BUSY: begin
        if (!access) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ACK;
          if (gnt_g_q) g_ack_d = 1'b1;
          else         f_ack_d = 1'b1;
          if (!wre_q) begin
            if (gnt_g_q) g_dto_d = rd_data;
            else         f_dto_d = rd_data;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_g_q <= 1'b1;
      gnt_g_q  <= 1'b0;
      wre_q    <= 1'b0;
      adr_q    <= '0;
      dti_q    <= '0;
      cnt_q    <= '0;
      g_ack_q  <= 1'b0;
      f_ack_q  <= 1'b0;
      g_dto_q  <= '0;
      f_dto_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_g_q <= last_g_d;
      gnt_g_q  <= gnt_g_d;
      wre_q    <= wre_d;
      adr_q    <= adr_d;
      dti_q    <= dti_d;
      cnt_q    <= cnt_d;
      g_ack_q  <= g_ack_d;
      f_ack_q  <= f_ack_d;
      g_dto_q  <= g_dto_d;
      f_dto_q  <= f_dto_d;
    end
  end

  // NOTE: the RAM array has no reset; rst only blocks a write that would land on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && access && wre_q) mem[adr_q] <= dti_q;
  end

  assign g_ack = g_ack_q;
  assign f_ack = f_ack_q;
  assign g_dto = g_dto_q;
  assign f_dto = f_dto_q;

endmodule
